bk_limb_add_sched: RTL and testbench
====================================

Name: bk_limb_add_sched

Overview:
- Scheduler that shares one 16-bit Brent-Kung adder between two requesters.
- Each requester submits a multi-limb add or subtract as a stream of 16-bit limbs, least-significant limb first; the last limb is flagged.
- The block arbitrates round-robin, locks the adder to the owner until that owner's last limb is accepted, and chains the carry between limbs.
- It registers each limb sum into a one-entry response stage with valid/ready handshake.

Parameters:
- WIDTH, 16, limb width; must equal the adder width. No other value is supported.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous active-high reset.
- Req0_Valid  in  1  requester 0 limb valid.
- Req0_Ready  out  1  requester 0 limb accepted this cycle when high with Req0_Valid.
- Req0_A  in  [16:1]  requester 0 operand A limb.
- Req0_B  in  [16:1]  requester 0 operand B limb.
- Req0_Sub  in  1  subtract; sampled on the first limb of an op only.
- Req0_Last  in  1  final limb of the op.
- Req1_Valid, Req1_Ready, Req1_A, Req1_B, Req1_Sub, Req1_Last: same as requester 0, for requester 1.
- Add_A  out  [16:1]  adder operand A (combinational from the granted requester).
- Add_B  out  [16:1]  adder operand B (B, or ~B when subtracting).
- Add_Cin  out  1  adder carry-in.
- Add_Sum  in  [17:1]  adder result; bit 17 is carry-out. Combinational return, same cycle.
- Rsp_Valid  out  1  response valid.
- Rsp_Ready  in  1  response consumer ready.
- Rsp_Sum  out  [16:1]  limb sum.
- Rsp_Id  out  1  owning requester.
- Rsp_Last  out  1  final limb of the op.
- Rsp_Cout  out  1  final carry-out (not-borrow for subtract); valid with Rsp_Last, else 0.
- Rsp_Ovf  out  1  signed overflow of the full-width op; valid with Rsp_Last, else 0.

Behaviour:
- Reset: all registers clear; Rst is sampled on the Clk edge.
  - State=IDLE, Owner=0, RR_Ptr=0 (requester 0 preferred), Carry_q=0, Sub_q=0.
  - Rsp_Valid=0; Rsp_Sum, Rsp_Id, Rsp_Last, Rsp_Cout, Rsp_Ovf all 0.
  - Req*_Ready=0 while Rst is high.
- Reset mid-op: the op in flight and any pending response are discarded. The requester must restart from limb 0.
- Slot free: Slot_Free = !Rsp_Valid || Rsp_Ready.
- FSM states IDLE and OWN.
  - IDLE grant: if only one requester is valid, grant it. If both are valid, grant RR_Ptr's choice. The grant is combinational, so the first limb is accepted in the same cycle.
  - IDLE exit: accepting a non-last limb moves to OWN and sets Owner. Accepting a last limb stays in IDLE and flips RR_Ptr to the other requester.
  - OWN: only the Owner is served; the other requester sees Ready=0. The lock holds indefinitely if the Owner deasserts Valid.
  - OWN exit: accepting the Owner's last limb returns to IDLE and sets RR_Ptr to the non-owner. The next op may be accepted in the following cycle (IDLE arbitration).
- Ready: ReqN_Ready = granted(N) && Slot_Free && !Rst.
- Adder drive:
  - Add_A = granted A.
  - First limb: Add_Cin = Req_Sub and Add_B = Req_Sub ? ~B : B.
  - Later limbs: Add_Cin = Carry_q and Add_B = Sub_q ? ~B : B.
  - Outputs are driven even when no limb is accepted; they are don't-care then.
- On accept:
  - Rsp_Sum <= Add_Sum[16:1]; Rsp_Id <= granted id; Rsp_Last <= Last.
  - Carry_q <= Add_Sum[17]; Sub_q latched on the first limb.
  - If Last: Rsp_Cout <= Add_Sum[17] and Rsp_Ovf <= (A[16]==Add_B[16]) && (Add_Sum[16]!=A[16]). Otherwise both are 0.
  - Rsp_Valid <= 1.
- Response hold: if Rsp_Ready is high and nothing is accepted, Rsp_Valid <= 0. Response fields hold stable while Rsp_Valid && !Rsp_Ready.
- Latency: 1 cycle from accept to Rsp_Valid.
- Throughput: 1 limb per cycle while Rsp_Ready stays high; no bubble between back-to-back ops.
- A single-limb op (first == last) never enters OWN.
- A requester changing Sub mid-op has no effect; Sub_q governs.

Test Plan:
- Single limb: Req0 A=0xFFFF, B=0x0001, Sub=0, Last=1 -> next cycle Rsp_Valid=1, Sum=0x0000, Cout=1, Ovf=0, Id=0, Last=1.
- 32-bit add: Req1 limbs (0xFFFF,0x0001) then (0x0000,0x0000, Last) -> responses 0x0000 then 0x0001 (Last=1, Cout=0). Add_Cin=1 on the second limb.
- Subtract:
  - A=0x0005, B=0x0007, Sub=1, Last -> Sum=0xFFFE, Cout=0, Ovf=0.
  - A=0x8000, B=0x0001, Sub=1, Last -> Sum=0x7FFF, Cout=1, Ovf=1.
- Contention: after reset both valid, Req1 with a 3-limb op -> Req0 granted first. Req1_Ready=0 until Req0's last limb, then Req1 owns all 3 limbs. With both valid again -> Req0 granted.
- Backpressure: Rsp_Ready=0 for 3 cycles between limbs 1 and 2 of a 2-limb op (0xFFFF+0x0001, then 0+0) -> Ready=0, Rsp_Sum holds 0x0000, second response is still 0x0001.
- Reset mid-op: Rst pulsed after limb 1 of 3 -> next cycle Rsp_Valid=0, state IDLE, Carry_q=0. A fresh Req1 op 0x0001+0x0001 then yields 0x0002 with Add_Cin=0.

Source files
------------

// File: rtl/bk_limb_add_sched.sv
// bk_limb_add_sched: shares one external 16-bit adder between two requesters.
// Each requester streams limbs LS-first. Arbitration is round-robin. The adder
// stays locked to the owner until its last limb, and the carry is chained.
// Ports: Clk/Rst (sync, active-high); Req0_*/Req1_* limb request channels;
//        Add_* drive and return of the external adder; Rsp_* response stage.
module bk_limb_add_sched #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Req0_Valid,
    output logic             Req0_Ready,
    input  logic [WIDTH:1]   Req0_A,
    input  logic [WIDTH:1]   Req0_B,
    input  logic             Req0_Sub,
    input  logic             Req0_Last,
    input  logic             Req1_Valid,
    output logic             Req1_Ready,
    input  logic [WIDTH:1]   Req1_A,
    input  logic [WIDTH:1]   Req1_B,
    input  logic             Req1_Sub,
    input  logic             Req1_Last,
    output logic [WIDTH:1]   Add_A,
    output logic [WIDTH:1]   Add_B,
    output logic             Add_Cin,
    input  logic [WIDTH+1:1] Add_Sum,
    output logic             Rsp_Valid,
    input  logic             Rsp_Ready,
    output logic [WIDTH:1]   Rsp_Sum,
    output logic             Rsp_Id,
    output logic             Rsp_Last,
    output logic             Rsp_Cout,
    output logic             Rsp_Ovf
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_owner;
    logic           w_owner_nxt;
    logic           r_rr_ptr;
    logic           w_rr_nxt;
    logic           r_carry;
    logic           r_sub;

    logic           r_rsp_valid;
    logic [WIDTH:1] r_rsp_sum;
    logic           r_rsp_id;
    logic           r_rsp_last;
    logic           r_rsp_cout;
    logic           r_rsp_ovf;

    logic           w_slot_free;
    logic           w_first;
    logic           w_gnt_vld;
    logic           w_gnt_id;
    logic           w_accept;
    logic [WIDTH:1] w_a;
    logic [WIDTH:1] w_b;
    logic [WIDTH:1] w_add_b;
    logic           w_sub_in;
    logic           w_sub_eff;
    logic           w_last;
    logic           w_cin;
    logic           w_ovf;

    // The response register can take a new limb if empty or draining now.
    assign w_slot_free = !r_rsp_valid || Rsp_Ready;
    assign w_first     = (r_state == S_IDLE);

    // Grant: in OWN only the owner is served, even if it has dropped Valid.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (r_state == S_OWN) begin
            w_gnt_id  = r_owner;
            w_gnt_vld = r_owner ? Req1_Valid : Req0_Valid;
        end else if (Req0_Valid && Req1_Valid) begin
            w_gnt_id  = r_rr_ptr;
            w_gnt_vld = 1'b1;
        end else if (Req1_Valid) begin
            w_gnt_id  = 1'b1;
            w_gnt_vld = 1'b1;
        end else if (Req0_Valid) begin
            w_gnt_vld = 1'b1;
        end
    end

    assign w_a      = w_gnt_id ? Req1_A    : Req0_A;
    assign w_b      = w_gnt_id ? Req1_B    : Req0_B;
    assign w_sub_in = w_gnt_id ? Req1_Sub  : Req0_Sub;
    assign w_last   = w_gnt_id ? Req1_Last : Req0_Last;

    // Subtract mode is taken from the request only on the first limb;
    // later limbs use the latched mode and the chained carry.
    assign w_sub_eff = w_first ? w_sub_in : r_sub;
    assign w_add_b   = w_sub_eff ? ~w_b : w_b;
    assign w_cin     = w_first ? w_sub_in : r_carry;

    assign Add_A   = w_a;
    assign Add_B   = w_add_b;
    assign Add_Cin = w_cin;

    // Signed overflow: like-signed adder operands, result sign differs.
    assign w_ovf = (w_a[WIDTH] == w_add_b[WIDTH])
                && (Add_Sum[WIDTH] != w_a[WIDTH]);

    assign w_accept   = w_gnt_vld && w_slot_free && !Rst;
    assign Req0_Ready = w_accept && !w_gnt_id;
    assign Req1_Ready = w_accept && w_gnt_id;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_rr_nxt = ~w_gnt_id;
                    end else begin
                        w_state_nxt = S_OWN;
                        w_owner_nxt = w_gnt_id;
                    end
                end
            end
            S_OWN: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = ~r_owner;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_cout  <= 1'b0;
            r_rsp_ovf   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
            if (w_accept) begin
                r_carry <= Add_Sum[WIDTH+1];
                if (w_first) begin
                    r_sub <= w_sub_in;
                end
                r_rsp_valid <= 1'b1;
                r_rsp_sum   <= Add_Sum[WIDTH:1];
                r_rsp_id    <= w_gnt_id;
                r_rsp_last  <= w_last;
                r_rsp_cout  <= w_last && Add_Sum[WIDTH+1];
                r_rsp_ovf   <= w_last && w_ovf;
            end else if (Rsp_Ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign Rsp_Valid = r_rsp_valid;
    assign Rsp_Sum   = r_rsp_sum;
    assign Rsp_Id    = r_rsp_id;
    assign Rsp_Last  = r_rsp_last;
    assign Rsp_Cout  = r_rsp_cout;
    assign Rsp_Ovf   = r_rsp_ovf;

endmodule

// File: tb/tb_bk_limb_add_sched.sv
// tb_bk_limb_add_sched: self-checking bench for bk_limb_add_sched.
// Models the external adder and scoreboards every response limb.
module tb_bk_limb_add_sched;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Req0_Valid, Req0_Ready, Req0_Sub, Req0_Last;
    logic [16:1] Req0_A, Req0_B;
    logic        Req1_Valid, Req1_Ready, Req1_Sub, Req1_Last;
    logic [16:1] Req1_A, Req1_B;
    logic [16:1] Add_A, Add_B;
    logic        Add_Cin;
    logic [17:1] Add_Sum;
    logic        Rsp_Valid, Rsp_Ready;
    logic [16:1] Rsp_Sum;
    logic        Rsp_Id, Rsp_Last, Rsp_Cout, Rsp_Ovf;

    typedef struct packed {
        logic [15:0] sum;
        logic        id;
        logic        last;
        logic        cout;
        logic        ovf;
    } rsp_t;

    rsp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   done;
    logic m_first[2];
    logic m_carry[2];
    logic m_sub[2];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cycle <= cycle + 1;

    assign Add_Sum = {1'b0, Add_A} + {1'b0, Add_B} + {16'd0, Add_Cin};

    bk_limb_add_sched #(.WIDTH(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready),
        .Req0_A(Req0_A), .Req0_B(Req0_B),
        .Req0_Sub(Req0_Sub), .Req0_Last(Req0_Last),
        .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready),
        .Req1_A(Req1_A), .Req1_B(Req1_B),
        .Req1_Sub(Req1_Sub), .Req1_Last(Req1_Last),
        .Add_A(Add_A), .Add_B(Add_B), .Add_Cin(Add_Cin),
        .Add_Sum(Add_Sum),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
        .Rsp_Sum(Rsp_Sum), .Rsp_Id(Rsp_Id), .Rsp_Last(Rsp_Last),
        .Rsp_Cout(Rsp_Cout), .Rsp_Ovf(Rsp_Ovf)
    );

    // Scoreboard: push expected limb on accept, pop on response handshake.
    always @(negedge Clk) begin
        rsp_t        got, ex;
        logic        v, sb, l, s, cin;
        logic [15:0] a, b, bx;
        logic [16:0] t;
        if (Rst) begin
            q.delete();
            for (int n = 0; n < 2; n++) begin
                m_first[n] = 1'b1;
                m_carry[n] = 1'b0;
                m_sub[n]   = 1'b0;
            end
        end else begin
            if (Rsp_Valid && Rsp_Ready) begin
                got = {Rsp_Sum, Rsp_Id, Rsp_Last, Rsp_Cout, Rsp_Ovf};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got=%h", got);
                end else begin
                    ex = q.pop_front();
                    if (got !== ex) begin
                        errors++;
                        $display("FAIL rsp got sum=%h id=%0d last=%0d cout=%0d ovf=%0d want sum=%h id=%0d last=%0d cout=%0d ovf=%0d",
                                 got.sum, got.id, got.last, got.cout, got.ovf,
                                 ex.sum, ex.id, ex.last, ex.cout, ex.ovf);
                    end
                end
            end
            if (Req0_Ready || Req1_Ready) begin
                checks++;
                if (Req0_Ready && Req1_Ready) begin
                    errors++;
                    $display("FAIL both_ready got=11 want one-hot");
                end
            end
            for (int n = 0; n < 2; n++) begin
                v  = (n == 1) ? (Req1_Valid && Req1_Ready) : (Req0_Valid && Req0_Ready);
                a  = (n == 1) ? Req1_A : Req0_A;
                b  = (n == 1) ? Req1_B : Req0_B;
                sb = (n == 1) ? Req1_Sub : Req0_Sub;
                l  = (n == 1) ? Req1_Last : Req0_Last;
                if (v) begin
                    s   = m_first[n] ? sb : m_sub[n];
                    bx  = s ? ~b : b;
                    cin = m_first[n] ? sb : m_carry[n];
                    t   = {1'b0, a} + {1'b0, bx} + {16'd0, cin};
                    ex.sum  = t[15:0];
                    ex.id   = (n == 1);
                    ex.last = l;
                    ex.cout = l & t[16];
                    ex.ovf  = l & (a[15] == bx[15]) & (t[15] != a[15]);
                    q.push_back(ex);
                    if (m_first[n]) m_sub[n] = sb;
                    m_carry[n] = t[16];
                    m_first[n] = l;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit id, input logic [15:0] a, b,
                         input bit sub, last);
        if (id) begin
            Req1_Valid = 1'b1; Req1_A = a; Req1_B = b;
            Req1_Sub = sub; Req1_Last = last;
        end else begin
            Req0_Valid = 1'b1; Req0_A = a; Req0_B = b;
            Req0_Sub = sub; Req0_Last = last;
        end
    endtask

    task automatic idle(input bit id);
        if (id) begin
            Req1_Valid = 1'b0; Req1_Last = 1'b0;
        end else begin
            Req0_Valid = 1'b0; Req0_Last = 1'b0;
        end
    endtask

    // Presents one limb and waits (bounded) for it to be accepted.
    task automatic send(input bit id, input logic [15:0] a, b,
                        input bit sub, last, output bit cin, output int cyc);
        bit got = 0;
        cin = 1'b0;
        cyc = -1;
        drive(id, a, b, sub, last);
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (!Rst && (id ? Req1_Ready : Req0_Ready)) begin
                got = 1;
                cin = Add_Cin;
                cyc = cycle;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout req%0d got=0 want=1", id);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        Rst = 1'b1;
        idle(0);
        idle(1);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Rsp_Ready = 1'b1;
        drive(0, 16'h1234, 16'h1111, 1'b0, 1'b1);
        idle(1);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (Req0_Ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b want=0", Req0_Ready);
        end
        checks++;
        if ({Rsp_Valid, Rsp_Sum, Rsp_Id, Rsp_Last, Rsp_Cout, Rsp_Ovf} !== 21'd0) begin
            errors++;
            $display("FAIL reset_rsp got v=%b sum=%h id=%b l=%b c=%b o=%b want all 0",
                     Rsp_Valid, Rsp_Sum, Rsp_Id, Rsp_Last, Rsp_Cout, Rsp_Ovf);
        end
        @(posedge Clk);
        #1;
        idle(0);
        Rst = 1'b0;
    endtask

    task automatic test_single();
        bit c; int y;
        send(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, c, y);
        idle(0);
        checks++;
        if ({Rsp_Valid, Rsp_Sum, Rsp_Id, Rsp_Last, Rsp_Cout, Rsp_Ovf} !== {1'b1, 16'h0000, 4'b0110}) begin
            errors++;
            $display("FAIL single got v=%b sum=%h id=%b l=%b c=%b o=%b want v=1 sum=0000 id=0 l=1 c=1 o=0",
                     Rsp_Valid, Rsp_Sum, Rsp_Id, Rsp_Last, Rsp_Cout, Rsp_Ovf);
        end
    endtask

    task automatic test_add32();
        bit c; int y;
        send(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, c, y);
        checks++;
        if (c !== 1'b0 || Rsp_Sum !== 16'h0000 || Rsp_Last !== 1'b0) begin
            errors++;
            $display("FAIL add32_lo got cin=%b sum=%h last=%b want cin=0 sum=0000 last=0",
                     c, Rsp_Sum, Rsp_Last);
        end
        send(1, 16'h0000, 16'h0000, 1'b0, 1'b1, c, y);
        idle(1);
        checks++;
        if (c !== 1'b1) begin
            errors++; $display("FAIL add32_cin got=%b want=1", c);
        end
        checks++;
        if (Rsp_Sum !== 16'h0001 || Rsp_Last !== 1'b1 || Rsp_Cout !== 1'b0 || Rsp_Id !== 1'b1) begin
            errors++;
            $display("FAIL add32_hi got sum=%h last=%b cout=%b id=%b want 0001 1 0 1",
                     Rsp_Sum, Rsp_Last, Rsp_Cout, Rsp_Id);
        end
    endtask

    task automatic test_sub();
        bit c; int y;
        send(0, 16'h0005, 16'h0007, 1'b1, 1'b1, c, y);
        idle(0);
        checks++;
        if (Rsp_Sum !== 16'hFFFE || Rsp_Cout !== 1'b0 || Rsp_Ovf !== 1'b0) begin
            errors++;
            $display("FAIL sub_5m7 got sum=%h cout=%b ovf=%b want FFFE 0 0",
                     Rsp_Sum, Rsp_Cout, Rsp_Ovf);
        end
        send(0, 16'h8000, 16'h0001, 1'b1, 1'b1, c, y);
        idle(0);
        checks++;
        if (Rsp_Sum !== 16'h7FFF || Rsp_Cout !== 1'b1 || Rsp_Ovf !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf got sum=%h cout=%b ovf=%b want 7FFF 1 1",
                     Rsp_Sum, Rsp_Cout, Rsp_Ovf);
        end
    endtask

    task automatic test_contention();
        int c0a, c0b, c1a, c1c, d0, d1;
        pulse_reset();
        fork
            begin
                bit c;
                send(0, 16'h1111, 16'h2222, 1'b0, 1'b0, c, c0a);
                send(0, 16'h3333, 16'h4444, 1'b0, 1'b1, c, c0b);
                idle(0);
            end
            begin
                bit c; int y;
                send(1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, c, c1a);
                send(1, 16'h0001, 16'h0002, 1'b0, 1'b0, c, y);
                send(1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, c, c1c);
                idle(1);
            end
        join
        checks++;
        if (!(c0a < c1a && c0b + 1 == c1a)) begin
            errors++;
            $display("FAIL contention_order got r0=%0d..%0d r1=%0d want r0 first, r1 right after",
                     c0a, c0b, c1a);
        end
        checks++;
        if (c1c != c1a + 2) begin
            errors++;
            $display("FAIL contention_lock got span=%0d want=2", c1c - c1a);
        end
        fork
            begin
                bit c;
                send(0, 16'h0100, 16'h0200, 1'b0, 1'b1, c, d0);
                idle(0);
            end
            begin
                bit c;
                send(1, 16'h0300, 16'h0400, 1'b0, 1'b1, c, d1);
                idle(1);
            end
        join
        checks++;
        if (!(d0 + 1 == d1)) begin
            errors++;
            $display("FAIL contention_rr got r0=%0d r1=%0d want r0 then r1", d0, d1);
        end
    endtask

    task automatic test_backpressure();
        bit c; int y;
        send(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, c, y);
        Rsp_Ready = 1'b0;
        drive(0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (Req0_Ready !== 1'b0 || Rsp_Valid !== 1'b1 || Rsp_Sum !== 16'h0000) begin
                errors++;
                $display("FAIL bp_hold got rdy=%b v=%b sum=%h want 0 1 0000",
                         Req0_Ready, Rsp_Valid, Rsp_Sum);
            end
        end
        @(posedge Clk);
        #1;
        Rsp_Ready = 1'b1;
        send(0, 16'h0000, 16'h0000, 1'b0, 1'b1, c, y);
        idle(0);
        checks++;
        if (Rsp_Sum !== 16'h0001 || Rsp_Last !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got sum=%h last=%b want 0001 1", Rsp_Sum, Rsp_Last);
        end
    endtask

    task automatic test_reset_midop();
        bit c; int y;
        send(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, c, y);
        pulse_reset();
        @(negedge Clk);
        checks++;
        if (Rsp_Valid !== 1'b0) begin
            errors++; $display("FAIL midrst_valid got=%b want=0", Rsp_Valid);
        end
        @(posedge Clk);
        #1;
        send(1, 16'h0001, 16'h0001, 1'b0, 1'b1, c, y);
        idle(1);
        checks++;
        if (c !== 1'b0 || Rsp_Sum !== 16'h0002 || Rsp_Last !== 1'b1) begin
            errors++;
            $display("FAIL midrst_fresh got cin=%b sum=%h last=%b want 0 0002 1",
                     c, Rsp_Sum, Rsp_Last);
        end
    endtask

    // Random multi-limb ops from both sides with random response backpressure;
    // Sub is re-randomised every limb, only the first limb's value counts.
    task automatic test_back_to_back();
        done = 0;
        fork
            begin
                bit c; int y, nl;
                for (int op = 0; op < 6; op++) begin
                    nl = $urandom_range(1, 3);
                    for (int k = 0; k < nl; k++)
                        send(0, 16'($urandom), 16'($urandom), 1'($urandom),
                             (k == nl - 1), c, y);
                    if ($urandom_range(0, 1) == 1) begin
                        idle(0);
                        @(posedge Clk);
                        #1;
                    end
                end
                idle(0);
                done++;
            end
            begin
                bit c; int y, nl;
                for (int op = 0; op < 6; op++) begin
                    nl = $urandom_range(1, 3);
                    for (int k = 0; k < nl; k++)
                        send(1, 16'($urandom), 16'($urandom), 1'($urandom),
                             (k == nl - 1), c, y);
                end
                idle(1);
                done++;
            end
            begin
                while (done < 2) begin
                    @(posedge Clk);
                    #1;
                    Rsp_Ready = ($urandom_range(0, 3) != 0);
                end
                Rsp_Ready = 1'b1;
            end
        join
        for (int i = 0; i < 20 && (q.size() != 0 || Rsp_Valid); i++)
            @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (q.size() != 0 || Rsp_Valid !== 1'b0) begin
            errors++;
            $display("FAIL drain got pending=%0d v=%b want 0 0", q.size(), Rsp_Valid);
        end
    endtask

    initial begin
        Rst = 1'b1;
        Rsp_Ready = 1'b1;
        Req0_Valid = 0; Req0_A = 0; Req0_B = 0; Req0_Sub = 0; Req0_Last = 0;
        Req1_Valid = 0; Req1_A = 0; Req1_B = 0; Req1_Sub = 0; Req1_Last = 0;
        #1;
        test_reset();
        test_single();
        test_add32();
        test_sub();
        test_contention();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        repeat (2) @(posedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
